// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter for four masters with a per-transfer abort timer.
// Each grant is held through one DONE cycle, and there is always an idle cycle between grants.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no grant; searches req from rr_ptr and grants the winner
// S_BUSY | grant held; waits for mem_done or the timer to expire
// S_DONE | grant held one more cycle while finish pulses to the owner
module bus_arbiter #(
   parameter int         NREQ    = 4,
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic            CLK,
   input  logic            CLR,
   input  logic [NREQ-1:0] req,
   input  logic            mem_done,
   input  logic            err_clr,
   output logic [NREQ-1:0] grant,
   output logic [NREQ-1:0] finish,
   output logic            busy,
   output logic [1:0]      owner,
   output logic            timeout_err,
   output logic [1:0]      err_owner
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [NREQ-1:0] finish_q, finish_d;
   logic            busy_q, busy_d;
   logic [1:0]      owner_q, owner_d;
   logic [1:0]      rr_ptr_q, rr_ptr_d;
   logic [7:0]      timer_q, timer_d;
   logic            timeout_err_q, timeout_err_d;
   logic [1:0]      err_owner_q, err_owner_d;

   logic            win_found;
   logic [1:0]      win_idx;
   logic [1:0]      idx;

   // Round-robin search: first requester at or after rr_ptr, wrapping past 3.
   always_comb begin
      win_found = 1'b0;
      win_idx   = rr_ptr_q;
      idx       = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = rr_ptr_q + 2'(k);
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win_idx   = idx;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      finish_d      = '0;
      owner_d       = owner_q;
      rr_ptr_d      = rr_ptr_q;
      timer_d       = timer_q;
      err_owner_d   = err_owner_q;
      timeout_err_d = err_clr ? 1'b0 : timeout_err_q;

      case (state_q)
         S_IDLE: begin
            grant_d = '0;
            if (win_found) begin
               state_d          = S_BUSY;
               grant_d[win_idx] = 1'b1;
               owner_d          = win_idx;
               timer_d          = '0;
            end
         end
         S_BUSY: begin
            // mem_done beats a simultaneous timer expiry, so no error in that case.
            if (mem_done) begin
               state_d  = S_DONE;
               finish_d = grant_q;
            end else if (timer_q == TIMEOUT - 8'd1) begin
               state_d       = S_DONE;
               finish_d      = grant_q;
               timeout_err_d = 1'b1;
               err_owner_d   = owner_q;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         S_DONE: begin
            state_d  = S_IDLE;
            grant_d  = '0;
            rr_ptr_d = owner_q + 2'd1;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase

      busy_d = |grant_d;
   end

   always_ff @(posedge CLK) begin
      if (!CLR) begin
         state_q       <= S_IDLE;
         grant_q       <= '0;
         finish_q      <= '0;
         busy_q        <= 1'b0;
         owner_q       <= '0;
         rr_ptr_q      <= '0;
         timer_q       <= '0;
         timeout_err_q <= 1'b0;
         err_owner_q   <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         finish_q      <= finish_d;
         busy_q        <= busy_d;
         owner_q       <= owner_d;
         rr_ptr_q      <= rr_ptr_d;
         timer_q       <= timer_d;
         timeout_err_q <= timeout_err_d;
         err_owner_q   <= err_owner_d;
      end
   end

   assign grant       = grant_q;
   assign finish      = finish_q;
   assign busy        = busy_q;
   assign owner       = owner_q;
   assign timeout_err = timeout_err_q;
   assign err_owner   = err_owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: the driver computes expected grants and finishes from
// round-robin and timeout rules, and the monitor pops and compares them as the DUT presents them.
module tb_bus_arbiter;

   localparam int TO = 4;

   logic       CLK = 1'b0;
   logic       CLR = 1'b0;
   logic [3:0] req = '0;
   logic       mem_done = 1'b0;
   logic       err_clr = 1'b0;
   logic [3:0] grant, finish;
   logic       busy, timeout_err;
   logic [1:0] owner, err_owner;

   bus_arbiter #(.NREQ(4), .TIMEOUT(8'(TO))) dut (
      .CLK(CLK), .CLR(CLR), .req(req), .mem_done(mem_done), .err_clr(err_clr),
      .grant(grant), .finish(finish), .busy(busy), .owner(owner),
      .timeout_err(timeout_err), .err_owner(err_owner)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   typedef struct { int w; int c; } gexp_t;
   typedef struct { int w; int c; int e; int eo; } fexp_t;
   gexp_t q_g[$];
   fexp_t q_f[$];

   // reference model state
   int rr_m = 0;
   int err_m = 0;
   int eo_m = 0;

   function automatic int pick(input int mask, input int rr);
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (rr + k) % 4;
         if (((mask >> i) & 1) == 1) return i;
      end
      return -1;
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
   // d: BUSY cycle index (0-based) on which mem_done is seen; d >= TO means it never arrives.
   task automatic txn(input int mask, input int d, input bit clr_start, input bit drop,
                      input bit clr_late);
      int w, g, last;
      bit ab;
      w    = pick(mask, rr_m);
      req  = 4'(mask);
      err_clr = clr_start;
      if (clr_start) err_m = 0;
      g    = cyc + 1;
      ab   = (d > TO - 1);
      last = ab ? TO - 1 : d;
      if (ab) begin
         err_m = 1;
         eo_m  = w;
      end
      q_g.push_back('{w, g});
      q_f.push_back('{w, g + last + 1, err_m, eo_m});
      rr_m = (w + 1) % 4;
      @(negedge CLK);
      err_clr = 1'b0;
      for (int i = 0; i <= last; i++) begin
         mem_done = (i == d);
         if (drop) req = (i == 0) ? (4'(mask) & ~(4'b0001 << w)) : 4'($urandom_range(0, 15));
         err_clr = clr_late && ab && (i == last);
         @(negedge CLK);
      end
      err_clr  = 1'b0;
      mem_done = 1'($urandom_range(0, 1));
      req      = 4'($urandom_range(0, 15));
      @(negedge CLK);
      mem_done = 1'b0;
      req      = '0;
   endtask

   task automatic idle(input int n);
      req = '0;
      for (int i = 0; i < n; i++) begin
         mem_done = 1'($urandom_range(0, 1));
         @(negedge CLK);
      end
      mem_done = 1'b0;
   endtask

   // monitor / scoreboard
   initial begin
      logic [3:0] pg, pf;
      gexp_t ge;
      fexp_t fe;
      pg = '0;
      pf = '0;
      forever begin
         @(negedge CLK);
         chk("busy_or", int'(busy), int'(|grant));
         chk("onehot", int'($countones(grant) <= 1 && $countones(finish) <= 1), 1);
         if (grant != 0 && pg == 0) begin
            if (q_g.size() == 0) chk("unexp_grant", int'(grant), 0);
            else begin
               ge = q_g.pop_front();
               chk("grant", int'(grant), 1 << ge.w);
               chk("owner", int'(owner), ge.w);
               chk("grant_cyc", cyc, ge.c);
            end
         end else if (grant != 0) begin
            chk("grant_hold", int'(grant), int'(pg));
         end
         if (finish != 0) begin
            if (q_f.size() == 0) chk("unexp_finish", int'(finish), 0);
            else begin
               fe = q_f.pop_front();
               chk("finish", int'(finish), 1 << fe.w);
               chk("finish_grant", int'(grant), 1 << fe.w);
               chk("finish_cyc", cyc, fe.c);
               chk("timeout_err", int'(timeout_err), fe.e);
               chk("err_owner", int'(err_owner), fe.eo);
            end
         end
         if (pf != 0) chk("turnaround", int'({grant, finish}), 0);
         pg = grant;
         pf = finish;
      end
   end

   initial begin
      CLR = 1'b0;
      repeat (2) @(negedge CLK);
      chk("reset_out", int'({grant, finish, busy, owner, timeout_err, err_owner}), 0);
      CLR = 1'b1;

      // single master, mem_done on third BUSY cycle
      txn(4'b0010, 2, 0, 0, 0);
      // all requesting: strict rotation starting at master 0
      txn(4'b1000, 1, 0, 0, 0);
      repeat (5) txn(4'b1111, 2, 0, 0, 0);
      // timeout abort then clear
      txn(4'b0001, TO + 1, 0, 0, 0);
      chk("err_set", int'(timeout_err), 1);
      chk("err_owner_set", int'(err_owner), 0);
      req = '0;
      err_clr = 1'b1;
      @(negedge CLK);
      err_clr = 1'b0;
      err_m = 0;
      chk("err_cleared", int'(timeout_err), 0);
      // mem_done coincides with timer expiry
      txn(4'b0100, TO - 1, 0, 0, 0);
      // owner drops req mid-transfer
      txn(4'b1000, 3, 0, 1, 0);
      // err_clr coincides with abort: set wins
      txn(4'b0010, TO, 0, 0, 1);
      chk("err_set_wins", int'(timeout_err), 1);

      for (int n = 0; n < 150; n++) begin
         idle($urandom_range(0, 2));
         txn($urandom_range(1, 15), $urandom_range(0, TO + 1), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // reset mid-BUSY with grant 0100 and a pending error
      txn(4'b0001, TO, 0, 0, 0);
      begin
         int g;
         req = 4'b0100;
         g = cyc + 1;
         q_g.push_back('{pick(4'b0100, rr_m), g});
         @(negedge CLK);
         @(negedge CLK);
         CLR = 1'b0;
         @(negedge CLK);
         chk("mid_reset_out", int'({grant, finish, busy, owner, timeout_err, err_owner}), 0);
         CLR = 1'b1;
         req = '0;
         rr_m = 0;
         err_m = 0;
         eo_m = 0;
      end
      idle(3);
      txn(4'b1111, 1, 0, 0, 0);
      chk("post_reset_owner", int'(owner), 0);
      idle(3);

      chk("queues_empty", q_g.size() + q_f.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
